// File: rtl/snes_bus_pkg.sv
// Shared B-bus definitions for the 21FX SNES port blocks: address map,
// entry tag encoding, status byte layout and synchronizer depth.
package snes_bus_pkg;

  // B-bus low addresses ($21xx)
  localparam logic [7:0] BOOT_ROM_BASE   = 8'h84;
  localparam logic [7:0] VEC_LO_ADDR     = 8'hFC;
  localparam logic [7:0] VEC_HI_ADDR     = 8'hFD;
  localparam logic [7:0] DATA_ADDR_DEF   = 8'hFF;
  localparam logic [7:0] CTRL_ADDR_DEF   = 8'hFE;
  localparam logic [7:0] STATUS_ADDR_DEF = 8'hFD;

  // Tag carried with each captured byte
  typedef enum logic {
    TAG_DATA = 1'b0,
    TAG_CTRL = 1'b1
  } wr_tag_e;

  // Status byte layout: {overflow, full, empty, level[4:0]}
  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_LEVEL_W   = 5;

  // Flops per asynchronous input before it is considered stable
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/snes_wr_fifo.sv
// Single-clock FIFO for captured B-bus writes. Pointers are one bit wider
// than the address so full/empty and level fall out of a plain difference.
// Output is the raw head entry; the parent gates it with its valid flag.
module snes_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO only lands if the head leaves on the same edge
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read/write pointers, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/snes_wr_capture.sv
// SNES-to-host capture of B-bus writes to the 21FX data/control ports.
// Raw PAWR_n/addr/data are synchronized, the write strobe is glitch
// filtered, and qualified writes are queued as {tag, byte} entries that
// drain through a valid/ready stream. This block never drives D itself.
// Optional feature macro: SNES_WR_STATUS_EN adds a registered status byte
// (status_oe/status_dout) readable at STATUS_ADDR via PARD_n.
module snes_wr_capture
  import snes_bus_pkg::*;
#(
  parameter logic [7:0] DATA_ADDR   = DATA_ADDR_DEF,
  parameter logic [7:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         MIN_LOW     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    addr,
  input  logic [7:0]                    data,
  input  logic                          PAWR_n,
  input  logic                          PARD_n,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic                          m_tag,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          status_oe,
  output logic [7:0]                    status_dout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       pawr_s1, pawr_s2, pawr_s3;
  logic [7:0] addr_s1, addr_s2, addr_s3;
  logic [7:0] data_s1, data_s2, data_s3;
  logic [7:0] low_cnt;
  logic       wr_evt;
  logic       hit_data;
  logic       hit_ctrl;
  logic       push;
  logic       pop;
  logic       ovf_set;
  logic [8:0] fifo_din;
  logic [8:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  // Strobe synchronizer; idles high so reset release never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pawr_s1 <= 1'b1;
      pawr_s2 <= 1'b1;
      pawr_s3 <= 1'b1;
    end else begin
      pawr_s1 <= PAWR_n;
      pawr_s2 <= pawr_s1;
      pawr_s3 <= pawr_s2;
    end
  end

  // Address/data follow the strobe through matching stages; s3 holds the bus while strobe was low
  always_ff @(posedge clk) begin
    addr_s1 <= addr;
    addr_s2 <= addr_s1;
    addr_s3 <= addr_s2;
    data_s1 <= data;
    data_s2 <= data_s1;
    data_s3 <= data_s2;
  end

  // Saturating count of consecutive synced-low strobe cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              low_cnt <= '0;
    else if (pawr_s2)        low_cnt <= '0;
    else if (low_cnt != '1)  low_cnt <= low_cnt + 1'b1;
  end

  // Rising edge of a strobe that stayed low long enough is a real write
  assign wr_evt   = !pawr_s3 && pawr_s2 && (low_cnt >= 8'(MIN_LOW));
  assign hit_data = (addr_s3 == DATA_ADDR);
  assign hit_ctrl = (addr_s3 == CTRL_ADDR);
  assign push     = wr_evt && (hit_data || hit_ctrl);
  assign fifo_din = {hit_ctrl, data_s3};
  assign pop      = m_valid && m_ready;
  assign ovf_set  = push && fifo_full && !pop;

  snes_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_dout[7:0] : 8'h00;
  assign m_tag   = m_valid ? fifo_dout[8]   : 1'b0;

  // Sticky overflow; a fresh drop beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef SNES_WR_STATUS_EN
  logic       pard_s1, pard_s2;
  logic       stat_sel;
  logic [7:0] stat_byte;

  function automatic logic [STAT_LEVEL_W-1:0] sat_level(input logic [AW:0] lv);
    int v;
    v = int'(lv);
    if (v > (1 << STAT_LEVEL_W) - 1) return '1;
    return STAT_LEVEL_W'(v);
  endfunction

  // Read strobe synchronizer, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pard_s1 <= 1'b1;
      pard_s2 <= 1'b1;
    end else begin
      pard_s1 <= PARD_n;
      pard_s2 <= pard_s1;
    end
  end

  assign stat_sel = !pard_s2 && (addr_s2 == STATUS_ADDR);

  // Assemble the status byte from live FIFO state
  always_comb begin
    stat_byte                 = 8'h00;
    stat_byte[STAT_OVF_BIT]   = overflow;
    stat_byte[STAT_FULL_BIT]  = fifo_full;
    stat_byte[STAT_EMPTY_BIT] = fifo_empty;
    stat_byte[STAT_LEVEL_W-1:0] = sat_level(level);
  end

  // Registered status drive toward the top-level D bus mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_oe   <= 1'b0;
      status_dout <= 8'h00;
    end else begin
      status_oe   <= stat_sel;
      status_dout <= stat_sel ? stat_byte : 8'h00;
    end
  end
`else
  logic unused_pard;
  assign unused_pard = PARD_n;
  assign status_oe   = 1'b0;
  assign status_dout = 8'h00;
`endif

endmodule

// File: tb/tb_snes_wr_capture.sv
// Scoreboard bench for snes_wr_capture: stimulus pushes expected {tag,byte}
// entries, a negedge monitor pops and compares every stream handshake.
module tb_snes_wr_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       PAWR_n = 1'b1;
  logic       PARD_n = 1'b1;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_tag;
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       status_oe;
  logic [7:0] status_dout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] sb_q[$];

  snes_wr_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .data        (data),
    .PAWR_n      (PAWR_n),
    .PARD_n      (PARD_n),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_tag       (m_tag),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .status_oe   (status_oe),
    .status_dout (status_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  // One SNES write: strobe low for 'low' sampled clocks, then a 4-clock gap
  task automatic snes_wr(input logic [7:0] a, input logic [7:0] d, input int low, input bit exp);
    at_pos();
    addr = a; data = d; PAWR_n = 1'b0;
    if (exp) sb_q.push_back({(a == 8'hFE), d});
    repeat (low) at_pos();
    PAWR_n = 1'b1;
    repeat (4) at_pos();
  endtask

  task automatic drain(input string name);
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !m_valid) break;
    end
    at_pos();
    m_ready = 1'b0;
    check(name, 16'(sb_q.size()), 16'd0);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none", {m_tag, m_data});
      end else begin
        check("sb_beat", 16'({m_tag, m_data}), 16'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    int lat;
    repeat (3) at_pos();
    @(negedge clk);
    check("rst_m_valid", 16'(m_valid), 16'd0);
    check("rst_m_data", 16'(m_data), 16'd0);
    check("rst_m_tag", 16'(m_tag), 16'd0);
    check("rst_level", 16'(level), 16'd0);
    check("rst_overflow", 16'(overflow), 16'd0);
    check("rst_status_oe", 16'(status_oe), 16'd0);
    check("rst_status_dout", 16'(status_dout), 16'd0);
    at_pos();
    rst_n = 1'b1;
    repeat (3) at_pos();

    // 1: single data write, latency from strobe rise
    m_ready = 1'b1;
    addr = 8'hFF; data = 8'h5A; PAWR_n = 1'b0;
    sb_q.push_back({1'b0, 8'h5A});
    repeat (8) at_pos();
    PAWR_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (m_valid) begin
        lat = i;
        break;
      end
    end
    check("t1_latency_1to4", 16'(lat >= 1 && lat <= 4), 16'd1);
    check("t1_data_at_valid", 16'({m_tag, m_data}), 16'h05A);
    drain("t1_drained");

    // 2: control then data, held off, then released in order
    snes_wr(8'hFE, 8'h01, 4, 1'b1);
    snes_wr(8'hFF, 8'hAA, 4, 1'b1);
    @(negedge clk);
    check("t2_level", 16'(level), 16'd2);
    check("t2_head", 16'({m_tag, m_data}), 16'h101);
    drain("t2_drained");

    // 3: non-port addresses are ignored
    snes_wr(8'h84, 8'h33, 4, 1'b0);
    snes_wr(8'hFD, 8'h33, 4, 1'b0);
    @(negedge clk);
    check("t3_level", 16'(level), 16'd0);
    check("t3_m_valid", 16'(m_valid), 16'd0);

    // 4: glitch filter threshold
    snes_wr(8'hFF, 8'h11, 2, 1'b0);
    @(negedge clk);
    check("t4_short_level", 16'(level), 16'd0);
    snes_wr(8'hFF, 8'h22, 3, 1'b1);
    @(negedge clk);
    check("t4_min_level", 16'(level), 16'd1);
    drain("t4_drained");

    // 5: overflow on the 17th write
    for (int i = 0; i < 17; i++) snes_wr(8'hFF, 8'(i), 4, i < 16);
    @(negedge clk);
    check("t5_level_full", 16'(level), 16'd16);
    check("t5_overflow", 16'(overflow), 16'd1);
    at_pos(); ovf_clr = 1'b1;
    at_pos(); ovf_clr = 1'b0;
    @(negedge clk);
    check("t5_ovf_cleared", 16'(overflow), 16'd0);

    // full + pop + push on the same edge: accepted
    at_pos();
    addr = 8'hFF; data = 8'h20; PAWR_n = 1'b0;
    repeat (4) at_pos();
    PAWR_n = 1'b1;
    at_pos(); at_pos();
    m_ready = 1'b1;
    sb_q.push_back({1'b0, 8'h20});
    at_pos();
    m_ready = 1'b0;
    repeat (2) at_pos();
    @(negedge clk);
    check("t5_pushpop_level", 16'(level), 16'd16);
    check("t5_pushpop_ovf", 16'(overflow), 16'd0);

    // full + drop coinciding with ovf_clr: set wins
    at_pos();
    addr = 8'hFF; data = 8'h30; PAWR_n = 1'b0;
    repeat (4) at_pos();
    PAWR_n = 1'b1;
    at_pos(); at_pos();
    ovf_clr = 1'b1;
    at_pos();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("t5_set_wins", 16'(overflow), 16'd1);
    at_pos(); ovf_clr = 1'b1;
    at_pos(); ovf_clr = 1'b0;
    drain("t5_drained");

    // 6: status read with three entries queued
    snes_wr(8'hFF, 8'h41, 4, 1'b1);
    snes_wr(8'hFF, 8'h42, 4, 1'b1);
    snes_wr(8'hFF, 8'h43, 4, 1'b1);
    at_pos();
    addr = 8'hFD; PARD_n = 1'b0;
    repeat (4) at_pos();
    @(negedge clk);
`ifdef SNES_WR_STATUS_EN
    check("t6_status_oe", 16'(status_oe), 16'd1);
    check("t6_status_dout", 16'(status_dout), 16'h03);
`else
    check("t6_status_oe_off", 16'(status_oe), 16'd0);
    check("t6_status_dout_off", 16'(status_dout), 16'h00);
`endif
    at_pos();
    PARD_n = 1'b1;
    repeat (3) at_pos();
    @(negedge clk);
    check("t6_status_oe_drop", 16'(status_oe), 16'd0);

    // reset in the middle of a write
    at_pos();
    addr = 8'hFF; data = 8'h77; PAWR_n = 1'b0;
    repeat (2) at_pos();
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", 16'(level), 16'd0);
    check("t6_rst_m_valid", 16'(m_valid), 16'd0);
    check("t6_rst_overflow", 16'(overflow), 16'd0);
    sb_q.delete();
    PAWR_n = 1'b1;
    at_pos(); at_pos();
    rst_n = 1'b1;
    repeat (6) at_pos();
    @(negedge clk);
    check("t6_post_rst_level", 16'(level), 16'd0);
    check("t6_post_rst_valid", 16'(m_valid), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
